// File: rtl/sram_rw_ctrl.sv
// sram_rw_ctrl
// Requester-side controller for a single-port SRAM macro with a one-cycle
// read latency (DEPTH x DATA_W, LANES write-mask lanes of LANE_W bits).
//
// Ports
//   clock, reset_n         clock and asynchronous active-low reset
//   req_valid/req_ready    request handshake; req_write selects write (1) or read (0)
//   req_addr               entry address
//   req_wmask, req_wdata   per-lane write enable and write data
//   resp_valid/resp_ready  read-response handshake
//   resp_rdata             read data, returned in request order
//   init_done              high once the array has been initialised
//   sram_addr/en/wmode/wmask/wdata  macro RW port outputs
//   sram_rdata             macro read data, valid the cycle after a read issue
//
// After reset the array is optionally zero-filled, one entry per cycle.
// Requests are then passed combinationally to the macro in their accept
// cycle. Read data is either bypassed straight to the response channel or
// parked in a 2-entry buffer when the consumer stalls.

module sram_rw_ctrl #(
  parameter int DEPTH         = 128,
  parameter int ADDR_W        = 7,
  parameter int LANES         = 4,
  parameter int LANE_W        = 37,
  parameter int DATA_W        = LANES * LANE_W,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LANES-1:0]  req_wmask,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [LANES-1:0]  sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] init_ptr;
  logic              init_done_q;

  logic              inflight;
  logic [1:0]        count;
  logic              head;
  logic [DATA_W-1:0] buf_data [2];

  logic [1:0]        occupancy;
  logic              issue;
  logic              rd_issue;
  logic              push;
  logic              pop;

  // Flow control only looks at registered state, so resp_ready never
  // reaches req_ready combinationally. At most two reads can be owed to the
  // consumer at any time: buffered entries plus the one in the macro.
  assign occupancy = count + {1'b0, inflight};
  assign req_ready = init_done_q && (occupancy < 2'd2);
  assign issue     = req_valid && req_ready;
  assign rd_issue  = issue && !req_write;
  assign init_done = init_done_q;

  // With an empty buffer the macro output is bypassed to the consumer;
  // otherwise the buffer head is presented and fresh data queues behind it.
  assign resp_valid = (count != 2'd0) || inflight;
  assign resp_rdata = (count != 2'd0) ? buf_data[head] : sram_rdata;
  assign pop        = resp_ready && (count != 2'd0);
  assign push       = inflight && ((count != 2'd0) || !resp_ready);

  // Initialisation sweep and the init_done flag. With zero-fill disabled
  // the sweep is skipped and RUN is entered on the first edge after release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_INIT;
      init_ptr    <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (INIT_ON_RESET == 0) begin
            state       <= ST_RUN;
            init_done_q <= 1'b1;
          end else begin
            init_ptr <= init_ptr + 1'b1;
            if (init_ptr == ADDR_W'(DEPTH - 1)) begin
              state       <= ST_RUN;
              init_done_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          init_done_q <= 1'b1;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

  // Read tracking and the 2-entry response buffer. The push slot is
  // computed from the pre-update head/count, so a simultaneous pop and
  // push leaves the occupancy unchanged and keeps ordering intact.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= 1'b0;
      count    <= 2'd0;
      head     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
      end
    end else begin
      inflight <= rd_issue;
      if (push) begin
        buf_data[head ^ count[0]] <= sram_rdata;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Macro port drive. During the sweep the macro is written with zeros;
  // reset_n gates the sweep so the port stays quiet while reset is held.
  // In RUN the request fields pass straight through and only the enable
  // depends on the handshake.
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    if (state == ST_INIT) begin
      if ((INIT_ON_RESET != 0) && reset_n) begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = init_ptr;
        sram_wmask = '1;
      end
    end else begin
      sram_en    = issue;
      sram_wmode = req_write;
      sram_addr  = req_addr;
      sram_wmask = req_wmask;
      sram_wdata = req_wdata;
    end
  end

endmodule

// File: doc/sram_rw_ctrl.md
Name: sram_rw_ctrl

Overview:
- Requester-side controller for the single-port, 1-cycle-read-latency SRAM macro: 128 x 148-bit, 4 write-mask lanes of 37 bits.
- Accepts read/write requests on a valid/ready interface and drives the macro's RW port.
- Captures read data one cycle after issue and returns it on a back-pressurable response channel through a 2-entry buffer.
- Optionally zero-fills the whole array after reset before accepting traffic.

Parameters:
- DEPTH, 128, number of SRAM entries
- ADDR_W, 7, address width (log2 DEPTH)
- LANES, 4, write-mask lanes
- LANE_W, 37, bits per lane
- DATA_W, 148, LANES*LANE_W
- INIT_ON_RESET, 1, 1 = zero-fill the array after reset

Ports:
- clock  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  entry address
- req_wmask  in  LANES  per-lane write enable
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  read data valid
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  DATA_W  read data
- init_done  out  1  high once the array is initialised
- sram_addr  out  ADDR_W  macro address
- sram_en  out  1  macro enable
- sram_wmode  out  1  macro write mode
- sram_wmask  out  LANES  macro lane mask
- sram_wdata  out  DATA_W  macro write data
- sram_rdata  in  DATA_W  macro read data, valid the cycle after a read issue

Behaviour:
- Reset (async assert, sync release):
  - FSM to INIT; sweep pointer 0, inflight 0, buffer empty.
  - Outputs: req_ready=0, resp_valid=0, init_done=0, sram_en=0, sram_wmode=0, sram_addr=0, sram_wmask=0, sram_wdata=0.
  - Reset mid-operation discards in-flight reads and buffered responses and restarts INIT.
- FSM states:
  - INIT: one write per cycle; sram_en=1, sram_wmode=1, sram_wmask=all-ones, sram_wdata=0, sram_addr=pointer. The pointer increments each cycle; after writing DEPTH-1, go to RUN.
  - INIT_ON_RESET=0: INIT lasts zero cycles; RUN in the first cycle after reset release.
  - RUN: init_done=1 (registered, rises the cycle RUN is entered). req_ready=0 in INIT.
- Request issue (RUN), combinational to the macro in the accept cycle T:
  - sram_en = req_valid && req_ready.
  - sram_wmode = req_write; sram_addr = req_addr; sram_wmask = req_wmask; sram_wdata = req_wdata.
  - When idle: sram_en=0; other macro outputs hold the request fields (don't-care).
- Writes:
  - No response.
  - A write with mask 0 is still issued (en=1, wmode=1) and changes nothing.
- Reads:
  - inflight is set at the edge ending T. sram_rdata is valid in T+1.
  - T+1 with buffer empty: resp_valid=1, resp_rdata=sram_rdata (bypass, latency 1). If resp_ready=0, the data is written into the buffer at the end of T+1.
  - T+1 with buffer non-empty: the data is appended to the buffer tail.
  - resp_valid = buffer non-empty || (inflight && buffer empty). resp_rdata = buffer head when non-empty.
  - Response order equals request order.
- Flow control:
  - req_ready = init_done && (count + inflight) < 2, where count is buffer occupancy 0..2.
  - req_ready is independent of req_write and req_valid.
  - With resp_ready held high: one request per cycle, sustained.
- Simultaneous events:
  - Buffer pop and push in the same cycle leave count unchanged.
  - A read issued in the same cycle a response is popped is permitted only via the registered condition above; no combinational path from resp_ready to req_ready.
- Read-after-write to the same address in consecutive cycles returns the new data, since the macro has written by the read cycle.

Test Plan:
- Reset release, INIT_ON_RESET=1, then read addresses 0, 64, 127 -> init_done rises exactly 128 cycles after release; all three reads return 0; req_ready=0 throughout INIT.
- Write addr 5, mask 4'b1111, data A, then read addr 5 -> resp_valid one cycle after read accept, rdata=A.
- Write addr 9 mask 4'b1111 data all-ones, then mask 4'b0101 data 0, then read -> lanes 0 and 2 zero, lanes 1 and 3 all-ones (bits [73:37] and [147:111] set).
- Back-to-back reads of addrs 1..8, resp_ready=1 -> 8 consecutive resp_valid cycles, in order, no req_ready drop.
- resp_ready=0, issue reads -> exactly 2 reads accepted, then req_ready=0; raise resp_ready -> both returned in order, req_ready reasserts.
- Assert reset_n=0 with 2 buffered responses -> resp_valid=0 immediately; after release INIT re-runs and prior contents read back 0.
